pos_dispatcher: RTL
===================

// Module: pos_dispatcher
// PURPOSE
//  Transmit side of the PE position interface: streams one home cell's particle offsets, then its
//  neighbour-cell positions, into a PE on the home_offset / nb_pos channels, honouring the PE's
//  disp_back_pressure. Reads home and neighbour caches (1-cycle read latency) and sits between
//  the position caches and PE. One dispatch job runs per start pulse.
// PARAMETERS
//  FIFO_DEPTH   4    output staging FIFO entries, power of 2, >=2 (covers 2 in-flight reads)
//  PARTICLE_ID_WIDTH, OFFSET_WIDTH, POS_WIDTH: from MD_pkg, not overridden locally
// PORTS
//  clk                input  1      single clock, all logic posedge
//  rst                input  1      asynchronous, active-high reset
//  start              input  1      1-cycle job start; ignored unless busy==0
//  home_num           input  PID_W  home particle count for job (sampled at start)
//  nb_num             input  PID_W  neighbour particle count for job (sampled at start)
//  home_rd_en         output 1      home cache read strobe
//  home_rd_addr       output PID_W  home cache address, 0..home_num-1
//  home_rd_data       input  offset_packet_t  valid cycle after home_rd_en; parid field ignored
//  nb_rd_en           output 1      neighbour cache read strobe
//  nb_rd_addr         output PID_W  neighbour cache address, 0..nb_num-1
//  nb_rd_data         input  pos_packet_t  valid cycle after nb_rd_en; parid field ignored
//  home_offset        output offset_packet_t  to PE; parid = address+1
//  home_offset_valid  output 1      home_offset beat valid
//  nb_pos             output pos_packet_t  to PE; parid = address+1
//  nb_pos_valid       output 1      nb_pos beat valid
//  disp_back_pressure input  1      from PE; high = no beat may be emitted next cycle
//  busy               output 1      job in progress (start accepted .. done)
//  done               output 1      1-cycle pulse, job complete
// BEHAVIOUR
//  Reset: all outputs 0 (rd_en, valids, busy, done, addrs, packets); FIFO empty; state IDLE.
//  FSM: IDLE -start-> HOME (home_num>0) / NB (home_num==0, nb_num>0) / DONE (both 0).
//   HOME: issue home reads addr 0..home_num-1; after last issue -> NB (nb_num>0) else DRAIN.
//   NB: issue nb reads addr 0..nb_num-1; after last issue -> DRAIN.
//   DRAIN: wait FIFO empty and no read in flight and no output valid pending -> DONE.
//   DONE: done=1 for one cycle, busy=0 next cycle -> IDLE.
//  Read issue: at most one read per cycle (home or nb, never both); issued only when
//   fifo_count + inflight < FIFO_DEPTH. Return data pushed into FIFO tagged {is_nb}.
//  FIFO entry payload = tag + element + 3 coords (max of offset/pos widths) + address.
//  Output: each cycle where disp_back_pressure==0 (sampled at the edge) and FIFO non-empty, pop one
//   entry into registered output; drive home_offset+valid (tag 0) or nb_pos+valid (tag 1). Valids
//   one-cycle pulses per beat; never both high. Outputs hold last payload when valid low.
//  Ordering: every home beat emitted before the first nb beat; addresses emitted in ascending order.
//  parid = addr+1 (0 is reserved for "no particle"); counts up to 2^PID_W-2 supported.
//  Latency (no back pressure): start edge T -> rd_en at T+1 -> FIFO push T+2 -> first valid T+3;
//   then one beat per cycle. done asserted 2 cycles after last beat.
//  Back pressure: while high, no beats; reads continue until FIFO budget exhausted, no data lost.
//   Dropping bp resumes beats the cycle after with the next entry (no duplicate, no skip).
//  start while busy: ignored, counts not resampled. rst mid-job: everything cleared immediately,
//   no further rd_en/valid; next job needs a fresh start.
// TESTING
//  T1 home_num=15, nb_num=0, bp=0: 15 consecutive home_offset_valid beats parid 1..15, offsets
//     = cache contents, nb_pos_valid never high, done 2 cycles after beat 15.
//  T2 home_num=15, nb_num=30: after 15 home beats, 30 nb beats parid 1..15 then 16..30; element
//     fields pass through (e.g. 2'b01 / 2'b10); first nb beat directly follows last home beat.
//  T3 T2 with bp high for 5 cycles at nb beat 4, and bp toggling every cycle for 10 cycles: no
//     lost/duplicate parids, rd_en stops when FIFO+inflight=4, no valid in any cycle after bp=1.
//  T4 home_num=0, nb_num=0: done pulses T+1, no rd_en, no valids; busy high only that cycle.
//  T5 start pulsed again mid-job with different counts: ignored, original job completes unchanged.
//  T6 assert rst during nb beat 7: all outputs 0 within reset, FIFO empty; new start runs T1 cleanly.

Source files
------------

// File: rtl/pos_dispatcher_if.sv
// Shared MD packet types and the position-dispatch port bundle.
// The dispatcher connects through the master modport; the cache/PE side uses slave.
package MD_pkg;

    localparam int PARTICLE_ID_WIDTH = 8;
    localparam int ELEMENT_WIDTH     = 2;
    localparam int OFFSET_WIDTH      = 12;
    localparam int POS_WIDTH         = 16;
    localparam int COORD_WIDTH       =
        (OFFSET_WIDTH > POS_WIDTH) ? OFFSET_WIDTH : POS_WIDTH;

    typedef struct packed {
        logic [PARTICLE_ID_WIDTH-1:0] parid;
        logic [ELEMENT_WIDTH-1:0]     element;
        logic [OFFSET_WIDTH-1:0]      offset_x;
        logic [OFFSET_WIDTH-1:0]      offset_y;
        logic [OFFSET_WIDTH-1:0]      offset_z;
    } offset_packet_t;

    typedef struct packed {
        logic [PARTICLE_ID_WIDTH-1:0] parid;
        logic [ELEMENT_WIDTH-1:0]     element;
        logic [POS_WIDTH-1:0]         pos_x;
        logic [POS_WIDTH-1:0]         pos_y;
        logic [POS_WIDTH-1:0]         pos_z;
    } pos_packet_t;

endpackage

interface pos_dispatcher_if;
    import MD_pkg::*;

    logic                         start;
    logic [PARTICLE_ID_WIDTH-1:0] home_num;
    logic [PARTICLE_ID_WIDTH-1:0] nb_num;
    logic                         home_rd_en;
    logic [PARTICLE_ID_WIDTH-1:0] home_rd_addr;
    offset_packet_t               home_rd_data;
    logic                         nb_rd_en;
    logic [PARTICLE_ID_WIDTH-1:0] nb_rd_addr;
    pos_packet_t                  nb_rd_data;
    offset_packet_t               home_offset;
    logic                         home_offset_valid;
    pos_packet_t                  nb_pos;
    logic                         nb_pos_valid;
    logic                         disp_back_pressure;
    logic                         busy;
    logic                         done;

    modport master (
        input  start, home_num, nb_num,
        input  home_rd_data, nb_rd_data,
        input  disp_back_pressure,
        output home_rd_en, home_rd_addr,
        output nb_rd_en, nb_rd_addr,
        output home_offset, home_offset_valid,
        output nb_pos, nb_pos_valid,
        output busy, done
    );

    modport slave (
        output start, home_num, nb_num,
        output home_rd_data, nb_rd_data,
        output disp_back_pressure,
        input  home_rd_en, home_rd_addr,
        input  nb_rd_en, nb_rd_addr,
        input  home_offset, home_offset_valid,
        input  nb_pos, nb_pos_valid,
        input  busy, done
    );

endinterface

// File: rtl/pos_dispatcher.sv
// Streams one home cell's offsets, then its neighbour positions, into a PE.
// Cache reads are throttled so the staging FIFO can always absorb returns.
module pos_dispatcher
    import MD_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    pos_dispatcher_if.master bus
);

    localparam int PW = PARTICLE_ID_WIDTH;
    localparam int CW = COORD_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic                     is_nb;
        logic [ELEMENT_WIDTH-1:0] element;
        logic [CW-1:0]            x;
        logic [CW-1:0]            y;
        logic [CW-1:0]            z;
        logic [PW-1:0]            addr;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE, S_HOME, S_NB, S_DRAIN, S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  home_cnt, nb_cnt;
    logic [PW-1:0]  home_addr, nb_addr;
    logic           pend, pend_nb;
    logic [PW-1:0]  pend_addr;
    entry_t         fifo [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count, occ;
    entry_t         push_entry, head;
    logic           budget, issue_home, issue_nb;
    logic           last_home, last_nb, pop;
    offset_packet_t home_q;
    pos_packet_t    nb_q;
    logic           home_v, nb_v;

    // count+pend bounds what can still land in the FIFO
    assign occ        = count + {{AW{1'b0}}, pend};
    assign budget     = occ < DEPTH;
    assign issue_home = (state == S_HOME) && budget;
    assign issue_nb   = (state == S_NB) && budget;
    assign last_home  = home_addr == home_cnt - 1'b1;
    assign last_nb    = nb_addr == nb_cnt - 1'b1;
    assign head       = fifo[rd_ptr];
    assign pop        = (count != '0) && !bus.disp_back_pressure;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.home_num != '0)
                        state_nxt = S_HOME;
                    else if (bus.nb_num != '0)
                        state_nxt = S_NB;
                    else
                        state_nxt = S_DONE;
                end
            end
            S_HOME: begin
                if (issue_home && last_home)
                    state_nxt = (nb_cnt != '0) ? S_NB : S_DRAIN;
            end
            S_NB: begin
                if (issue_nb && last_nb)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (count == '0 && !pend && !home_v && !nb_v)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            home_cnt  <= '0;
            nb_cnt    <= '0;
            home_addr <= '0;
            nb_addr   <= '0;
            pend      <= 1'b0;
            pend_nb   <= 1'b0;
            pend_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.start) begin
                home_cnt  <= bus.home_num;
                nb_cnt    <= bus.nb_num;
                home_addr <= '0;
                nb_addr   <= '0;
            end else begin
                if (issue_home)
                    home_addr <= home_addr + 1'b1;
                if (issue_nb)
                    nb_addr <= nb_addr + 1'b1;
            end
            pend      <= issue_home || issue_nb;
            pend_nb   <= issue_nb;
            pend_addr <= issue_nb ? nb_addr : home_addr;
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.is_nb = pend_nb;
        push_entry.addr  = pend_addr;
        if (pend_nb) begin
            push_entry.element = bus.nb_rd_data.element;
            push_entry.x       = CW'(bus.nb_rd_data.pos_x);
            push_entry.y       = CW'(bus.nb_rd_data.pos_y);
            push_entry.z       = CW'(bus.nb_rd_data.pos_z);
        end else begin
            push_entry.element = bus.home_rd_data.element;
            push_entry.x       = CW'(bus.home_rd_data.offset_x);
            push_entry.y       = CW'(bus.home_rd_data.offset_y);
            push_entry.z       = CW'(bus.home_rd_data.offset_z);
        end
    end

    always_ff @(posedge clk) begin
        if (pend)
            fifo[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pend)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, pend}
                           - {{AW{1'b0}}, pop};
        end
    end

    // parid 0 means "no particle", so beats carry address+1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            home_q <= '0;
            nb_q   <= '0;
            home_v <= 1'b0;
            nb_v   <= 1'b0;
        end else begin
            home_v <= pop && !head.is_nb;
            nb_v   <= pop && head.is_nb;
            if (pop && !head.is_nb) begin
                home_q.parid    <= head.addr + 1'b1;
                home_q.element  <= head.element;
                home_q.offset_x <= head.x[OFFSET_WIDTH-1:0];
                home_q.offset_y <= head.y[OFFSET_WIDTH-1:0];
                home_q.offset_z <= head.z[OFFSET_WIDTH-1:0];
            end
            if (pop && head.is_nb) begin
                nb_q.parid   <= head.addr + 1'b1;
                nb_q.element <= head.element;
                nb_q.pos_x   <= head.x[POS_WIDTH-1:0];
                nb_q.pos_y   <= head.y[POS_WIDTH-1:0];
                nb_q.pos_z   <= head.z[POS_WIDTH-1:0];
            end
        end
    end

    assign bus.home_rd_en        = issue_home;
    assign bus.home_rd_addr      = home_addr;
    assign bus.nb_rd_en          = issue_nb;
    assign bus.nb_rd_addr        = nb_addr;
    assign bus.home_offset       = home_q;
    assign bus.home_offset_valid = home_v;
    assign bus.nb_pos            = nb_q;
    assign bus.nb_pos_valid      = nb_v;
    assign bus.busy              = state != S_IDLE;
    assign bus.done              = state == S_DONE;

endmodule
